// File: rtl/abs_mag_pkg.sv
// abs_mag_pkg
//   Shared constants and helpers for the abs_mag_pipe gradient-magnitude stage.
//   CH_DEF / IN_W_DEF / OUT_W_DEF : default channel count and widths
//   SATCNT_W                      : width of the optional saturation counter
//   sat_add(a, b, out_w)          : unsigned add clipped to out_w bits,
//                                   returns {sat, mag} with mag in the low bits
package abs_mag_pkg;

  localparam int CH_DEF    = 4;
  localparam int IN_W_DEF  = 12;
  localparam int OUT_W_DEF = 12;
  localparam int SATCNT_W  = 16;

  // Fixed argument width for sat_add so one function serves every
  // parameterisation; callers zero-extend into it.
  localparam int SAT_ARG_W = 32;

  // Bit SAT_ARG_W of the result is the clip flag; bits [out_w-1:0] hold the
  // magnitude and everything between is zero.
  function automatic logic [SAT_ARG_W:0] sat_add(
    input logic [SAT_ARG_W-1:0] a,
    input logic [SAT_ARG_W-1:0] b,
    input int                   out_w
  );
    logic [SAT_ARG_W:0] sum;
    logic [SAT_ARG_W:0] limit;
    sum   = {1'b0, a} + {1'b0, b};
    limit = ((SAT_ARG_W+1)'(1) << out_w) - (SAT_ARG_W+1)'(1);
    if (sum > limit) begin
      return {1'b1, limit[SAT_ARG_W-1:0]};
    end else begin
      return {1'b0, sum[SAT_ARG_W-1:0]};
    end
  endfunction

endpackage

// File: rtl/abs_sat_unit.sv
// abs_sat_unit
//   Combinational absolute value of one signed two's-complement operand.
//   The result is IN_W bits unsigned, so the most negative input
//   -2^(IN_W-1) maps to exactly 2^(IN_W-1) instead of wrapping.
//   x     : signed operand
//   abs_x : unsigned |x|
module abs_sat_unit
  import abs_mag_pkg::*;
#(
  parameter int IN_W = IN_W_DEF
) (
  input  logic [IN_W-1:0] x,
  output logic [IN_W-1:0] abs_x
);

  // Negation in an unsigned IN_W-bit field: ~x + 1 of 100..0 is 100..0,
  // which read as unsigned is the correct magnitude.
  always_comb begin
    abs_x = x;
    if (x[IN_W-1]) begin
      abs_x = (~x) + IN_W'(1);
    end
  end

endmodule

// File: rtl/abs_mag_pipe.sv
// abs_mag_pipe
//   Two-stage pipelined gradient magnitude: per channel mag = |gx| + |gy|,
//   clipped to OUT_W bits, plus an edge flag (mag >= thresh sampled with
//   the beat) and a clip flag. Valid/ready on both sides, full throughput.
//   Optional build macro ABS_MAG_SATCNT_EN adds a 16-bit saturating count
//   of clipped channels on accepted output beats (port sat_count).
//
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : input handshake
//   in_gx, in_gy        : CH packed signed operands, channel k at [k*IN_W +: IN_W]
//   thresh              : edge threshold, captured with each accepted beat
//   out_valid/out_ready : output handshake
//   out_mag             : CH packed unsigned magnitudes
//   out_edge, out_sat   : per-channel threshold and clip flags
//   sat_count           : (ABS_MAG_SATCNT_EN only) clipped-channel counter
module abs_mag_pipe
  import abs_mag_pkg::*;
#(
  parameter int CH    = CH_DEF,
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CH*IN_W-1:0]    in_gx,
  input  logic [CH*IN_W-1:0]    in_gy,
  input  logic [OUT_W-1:0]      thresh,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CH*OUT_W-1:0]   out_mag,
  output logic [CH-1:0]         out_edge,
  output logic [CH-1:0]         out_sat
`ifdef ABS_MAG_SATCNT_EN
  ,
  output logic [SATCNT_W-1:0]   sat_count
`endif
);

  logic [CH-1:0][IN_W-1:0] abs_gx;
  logic [CH-1:0][IN_W-1:0] abs_gy;

  logic                    s1_valid_q, s1_valid_d;
  logic [CH-1:0][IN_W-1:0] s1_abs_gx_q, s1_abs_gx_d;
  logic [CH-1:0][IN_W-1:0] s1_abs_gy_q, s1_abs_gy_d;
  logic [OUT_W-1:0]        s1_thresh_q, s1_thresh_d;

  logic                    s2_valid_q, s2_valid_d;
  logic [CH*OUT_W-1:0]     s2_mag_q, s2_mag_d;
  logic [CH-1:0]           s2_edge_q, s2_edge_d;
  logic [CH-1:0]           s2_sat_q, s2_sat_d;

  logic                    s2_free;
  logic                    s1_advance;
  logic                    in_fire;
  logic [SAT_ARG_W:0]      sum_res [CH];

  for (genvar g = 0; g < CH; g++) begin : g_abs
    abs_sat_unit #(.IN_W(IN_W)) u_abs_gx (
      .x     (in_gx[g*IN_W +: IN_W]),
      .abs_x (abs_gx[g])
    );
    abs_sat_unit #(.IN_W(IN_W)) u_abs_gy (
      .x     (in_gy[g*IN_W +: IN_W]),
      .abs_x (abs_gy[g])
    );
  end

  // S2 can take a beat when empty or when its current beat leaves this
  // cycle; S1 can then refill in the same cycle, so in_ready depends
  // combinationally on out_ready and no bubble appears in steady state.
  always_comb begin
    s2_free    = ~s2_valid_q | out_ready;
    s1_advance = s1_valid_q & s2_free;
    in_ready   = ~s1_valid_q | s1_advance;
    in_fire    = in_valid & in_ready;
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_abs_gx_d = s1_abs_gx_q;
    s1_abs_gy_d = s1_abs_gy_q;
    s1_thresh_d = s1_thresh_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
    end
    if (in_fire) begin
      s1_abs_gx_d = abs_gx;
      s1_abs_gy_d = abs_gy;
      s1_thresh_d = thresh;
    end
  end

  always_comb begin
    for (int k = 0; k < CH; k++) begin
      sum_res[k] = sat_add(SAT_ARG_W'(s1_abs_gx_q[k]), SAT_ARG_W'(s1_abs_gy_q[k]), OUT_W);
    end
  end

  // S2 holds its outputs untouched while stalled so the downstream view is
  // stable until the handshake completes.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_mag_d   = s2_mag_q;
    s2_edge_d  = s2_edge_q;
    s2_sat_d   = s2_sat_q;
    if (s2_free) begin
      s2_valid_d = s1_valid_q;
    end
    if (s1_advance) begin
      for (int k = 0; k < CH; k++) begin
        s2_mag_d[k*OUT_W +: OUT_W] = sum_res[k][OUT_W-1:0];
        s2_sat_d[k]                = sum_res[k][SAT_ARG_W];
        s2_edge_d[k]               = (sum_res[k][OUT_W-1:0] >= s1_thresh_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_abs_gx_q <= '0;
      s1_abs_gy_q <= '0;
      s1_thresh_q <= '0;
      s2_valid_q  <= 1'b0;
      s2_mag_q    <= '0;
      s2_edge_q   <= '0;
      s2_sat_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_abs_gx_q <= s1_abs_gx_d;
      s1_abs_gy_q <= s1_abs_gy_d;
      s1_thresh_q <= s1_thresh_d;
      s2_valid_q  <= s2_valid_d;
      s2_mag_q    <= s2_mag_d;
      s2_edge_q   <= s2_edge_d;
      s2_sat_q    <= s2_sat_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_mag   = s2_mag_q;
  assign out_edge  = s2_edge_q;
  assign out_sat   = s2_sat_q;

`ifdef ABS_MAG_SATCNT_EN
  logic [SATCNT_W-1:0] sat_count_q, sat_count_d;
  logic [SATCNT_W:0]   sat_pop;
  logic [SATCNT_W:0]   sat_sum;

  // One extra bit on the sum catches the wrap so the counter pins at all-ones.
  always_comb begin
    sat_count_d = sat_count_q;
    sat_pop     = '0;
    for (int k = 0; k < CH; k++) begin
      sat_pop = sat_pop + (SATCNT_W+1)'(s2_sat_q[k]);
    end
    sat_sum = {1'b0, sat_count_q} + sat_pop;
    if (s2_valid_q && out_ready) begin
      sat_count_d = sat_sum[SATCNT_W] ? '1 : sat_sum[SATCNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_count_q <= '0;
    end else begin
      sat_count_q <= sat_count_d;
    end
  end

  assign sat_count = sat_count_q;
`endif

endmodule

// File: tb/tb_abs_mag_pipe.sv
// tb_abs_mag_pipe
//   Self-checking bench for abs_mag_pipe (CH=4, IN_W=12, OUT_W=12).
//   Expected beats come from an integer reference model of |gx|+|gy| with
//   clipping; streaming scenarios keep an in-order queue of expected beats.
//   Define ABS_MAG_SATCNT_EN to also exercise the saturation counter.
module tb_abs_mag_pipe;

  localparam int CH     = 4;
  localparam int IN_W   = 12;
  localparam int OUT_W  = 12;
  localparam int MAXMAG = 4095;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [CH*IN_W-1:0]  in_gx = '0;
  logic [CH*IN_W-1:0]  in_gy = '0;
  logic [OUT_W-1:0]    thresh = '0;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic [CH*OUT_W-1:0] out_mag;
  logic [CH-1:0]       out_edge;
  logic [CH-1:0]       out_sat;
`ifdef ABS_MAG_SATCNT_EN
  logic [15:0]         sat_count;
`endif

  typedef struct {
    logic [CH*OUT_W-1:0] mag;
    logic [CH-1:0]       edg;
    logic [CH-1:0]       sat;
  } beat_t;

  beat_t exp_q[$];
  int    inflight = 0;
  int    n_vec    = 0;
  int    n_fail   = 0;

  abs_mag_pipe #(.CH(CH), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_gx     (in_gx),
    .in_gy     (in_gy),
    .thresh    (thresh),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mag   (out_mag),
    .out_edge  (out_edge),
    .out_sat   (out_sat)
`ifdef ABS_MAG_SATCNT_EN
    ,
    .sat_count (sat_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Reference model: plain integer arithmetic on the signed channel values.
  function automatic beat_t model(input logic [CH*IN_W-1:0] gx,
                                  input logic [CH*IN_W-1:0] gy,
                                  input logic [OUT_W-1:0]   th);
    beat_t b;
    int x, y, s;
    for (int k = 0; k < CH; k++) begin
      x = int'($signed(gx[k*IN_W +: IN_W]));
      y = int'($signed(gy[k*IN_W +: IN_W]));
      if (x < 0) x = -x;
      if (y < 0) y = -y;
      s = x + y;
      b.sat[k] = (s > MAXMAG);
      if (s > MAXMAG) s = MAXMAG;
      b.mag[k*OUT_W +: OUT_W] = OUT_W'(s);
      b.edg[k] = (s >= int'(th));
    end
    return b;
  endfunction

  function automatic logic [CH*IN_W-1:0] pack4(input int c0, input int c1,
                                               input int c2, input int c3);
    logic [CH*IN_W-1:0] r;
    r[0*IN_W +: IN_W] = IN_W'(c0);
    r[1*IN_W +: IN_W] = IN_W'(c1);
    r[2*IN_W +: IN_W] = IN_W'(c2);
    r[3*IN_W +: IN_W] = IN_W'(c3);
    return r;
  endfunction

  // Random operands biased towards the extreme values.
  function automatic logic [CH*IN_W-1:0] rand_word();
    logic [CH*IN_W-1:0] r;
    for (int k = 0; k < CH; k++) begin
      case ($urandom_range(7))
        0:       r[k*IN_W +: IN_W] = 12'h800;
        1:       r[k*IN_W +: IN_W] = 12'h7FF;
        2:       r[k*IN_W +: IN_W] = 12'h801;
        default: r[k*IN_W +: IN_W] = IN_W'($urandom);
      endcase
    end
    return r;
  endfunction

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_gx     = '0;
    in_gy     = '0;
    thresh    = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    inflight = 0;
  endtask

  // Present one beat with out_ready=1 and leave the bench #1 after the edge
  // at which that beat lands in the output register.
  task automatic send_one(input logic [CH*IN_W-1:0] gx,
                          input logic [CH*IN_W-1:0] gy,
                          input logic [OUT_W-1:0]   th);
    in_gx     = gx;
    in_gy     = gy;
    thresh    = th;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    in_gx  = '0;
    in_gy  = '0;
    thresh = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    in_valid = 1'b1;
    in_gx    = pack4(5, 5, 5, 5);
    in_gy    = pack4(5, 5, 5, 5);
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    n_vec++; if (out_mag !== '0) begin n_fail++; $display("[TB] FAIL reset_out_mag: got %h want 0", out_mag); end
    n_vec++; if (out_edge !== '0) begin n_fail++; $display("[TB] FAIL reset_out_edge: got %b want 0", out_edge); end
    n_vec++; if (out_sat !== '0) begin n_fail++; $display("[TB] FAIL reset_out_sat: got %b want 0", out_sat); end
`ifdef ABS_MAG_SATCNT_EN
    n_vec++; if (sat_count !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_sat_count: got %0d want 0", sat_count); end
`endif
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_no_beat: got %b want 0", out_valid); end
  endtask

  task automatic test_basic();
    in_gx     = pack4(0, 100, -120, 7);
    in_gy     = pack4(0, -5, 20, -7);
    thresh    = 12'd100;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    thresh = 12'd0;
    n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_early_valid: got %b want 0", out_valid); end
    @(posedge clk);
    #1;
    n_vec++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_valid: got %b want 1", out_valid); end
    n_vec++; if (out_mag !== {12'd14, 12'd140, 12'd105, 12'd0}) begin n_fail++; $display("[TB] FAIL basic_mag: got %h want %h", out_mag, {12'd14, 12'd140, 12'd105, 12'd0}); end
    n_vec++; if (out_edge !== 4'b0110) begin n_fail++; $display("[TB] FAIL basic_edge: got %b want 0110", out_edge); end
    n_vec++; if (out_sat !== 4'b0000) begin n_fail++; $display("[TB] FAIL basic_sat: got %b want 0000", out_sat); end
    @(posedge clk);
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_no_dup: got %b want 0", out_valid); end
  endtask

  task automatic test_most_negative();
    send_one(pack4(-2048, -2048, -2048, -2048), pack4(-2048, -2048, -2048, -2048), 12'd0);
    n_vec++; if (out_mag !== {4{12'd4095}}) begin n_fail++; $display("[TB] FAIL neg_sat_mag: got %h want fff x4", out_mag); end
    n_vec++; if (out_sat !== 4'b1111) begin n_fail++; $display("[TB] FAIL neg_sat_flag: got %b want 1111", out_sat); end
    send_one(pack4(-2048, -2048, -2048, -2048), '0, 12'd2048);
    n_vec++; if (out_mag !== {4{12'd2048}}) begin n_fail++; $display("[TB] FAIL neg_abs_mag: got %h want 800 x4", out_mag); end
    n_vec++; if (out_sat !== 4'b0000) begin n_fail++; $display("[TB] FAIL neg_abs_sat: got %b want 0000", out_sat); end
    n_vec++; if (out_edge !== 4'b1111) begin n_fail++; $display("[TB] FAIL neg_abs_edge: got %b want 1111", out_edge); end
    // Sums of 4095 (no clip), 4094, 4096 (clip) and 1 at the clip boundary.
    send_one(pack4(-2048, 2047, -2048, 0), pack4(-2047, 2047, -2048, -1), 12'd4095);
    n_vec++; if (out_mag !== {12'd1, 12'd4095, 12'd4094, 12'd4095}) begin n_fail++; $display("[TB] FAIL bound_mag: got %h want %h", out_mag, {12'd1, 12'd4095, 12'd4094, 12'd4095}); end
    n_vec++; if (out_sat !== 4'b0100) begin n_fail++; $display("[TB] FAIL bound_sat: got %b want 0100", out_sat); end
    n_vec++; if (out_edge !== 4'b0101) begin n_fail++; $display("[TB] FAIL bound_edge: got %b want 0101", out_edge); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_threshold();
    out_ready = 1'b1;
    in_gx     = pack4(150, -150, 100, 0);
    in_gy     = pack4(0, 0, -50, -150);
    thresh    = 12'd50;
    in_valid  = 1'b1;
    @(posedge clk);
    #1 thresh = 12'd200;
    @(posedge clk);
    #1 in_valid = 1'b0;
    thresh = 12'd0;
    n_vec++; if (out_valid !== 1'b1 || out_edge !== 4'b1111 || out_mag !== {4{12'd150}}) begin n_fail++; $display("[TB] FAIL thresh_A: got v=%b edge=%b mag=%h want v=1 edge=1111 mag=096 x4", out_valid, out_edge, out_mag); end
    @(posedge clk);
    #1;
    n_vec++; if (out_valid !== 1'b1 || out_edge !== 4'b0000 || out_mag !== {4{12'd150}}) begin n_fail++; $display("[TB] FAIL thresh_B: got v=%b edge=%b mag=%h want v=1 edge=0000 mag=096 x4", out_valid, out_edge, out_mag); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_pressure();
    int    sent = 0;
    int    recv = 0;
    bit    held = 1'b0;
    logic  exp_ready;
    beat_t hv;
    beat_t e;
    for (int c = 0; c < 100 && recv < 8; c++) begin
      in_valid  = (sent < 8);
      in_gx     = pack4(sent + 1, sent + 1, -(sent + 1), sent + 1);
      in_gy     = '0;
      thresh    = OUT_W'(3 + (sent % 3));
      out_ready = ((c % 4) == 0) || ((c % 4) == 3);
      @(negedge clk);
      if (held) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_mag !== hv.mag || out_edge !== hv.edg || out_sat !== hv.sat) begin
          n_fail++; $display("[TB] FAIL bp_hold: got v=%b mag=%h want v=1 mag=%h", out_valid, out_mag, hv.mag);
        end
      end
      exp_ready = !(inflight == 2 && !out_ready);
      n_vec++; if (in_ready !== exp_ready) begin n_fail++; $display("[TB] FAIL bp_in_ready: cycle %0d got %b want %b", c, in_ready, exp_ready); end
      held   = out_valid && !out_ready;
      hv.mag = out_mag;
      hv.edg = out_edge;
      hv.sat = out_sat;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_fail++; $display("[TB] FAIL bp_extra: got beat mag=%h want none", out_mag);
        end else begin
          e = exp_q.pop_front();
          n_vec++;
          if (out_mag !== e.mag || out_edge !== e.edg || out_sat !== e.sat) begin
            n_fail++; $display("[TB] FAIL bp_data: got %h/%b/%b want %h/%b/%b", out_mag, out_edge, out_sat, e.mag, e.edg, e.sat);
          end
          inflight--;
        end
        recv++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_gx, in_gy, thresh));
        sent++;
        inflight++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    n_vec++; if (recv != 8 || exp_q.size() != 0) begin n_fail++; $display("[TB] FAIL bp_count: got %0d beats (%0d pending) want 8 (0)", recv, exp_q.size()); end
  endtask

  task automatic test_random_stream();
    int    recv = 0;
    int    sent = 0;
    bit    held = 1'b0;
    logic  exp_ready;
    beat_t hv;
    beat_t e;
    for (int c = 0; c < 700; c++) begin
      if (c >= 400 && inflight == 0) break;
      in_valid  = (c < 400) && ($urandom_range(3) != 0);
      in_gx     = rand_word();
      in_gy     = rand_word();
      thresh    = OUT_W'($urandom);
      out_ready = (c >= 400) || ($urandom_range(4) > 1);
      @(negedge clk);
      if (held) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_mag !== hv.mag || out_edge !== hv.edg || out_sat !== hv.sat) begin
          n_fail++; $display("[TB] FAIL rnd_hold: got v=%b mag=%h want v=1 mag=%h", out_valid, out_mag, hv.mag);
        end
      end
      exp_ready = !(inflight == 2 && !out_ready);
      n_vec++; if (in_ready !== exp_ready) begin n_fail++; $display("[TB] FAIL rnd_in_ready: cycle %0d got %b want %b", c, in_ready, exp_ready); end
      held   = out_valid && !out_ready;
      hv.mag = out_mag;
      hv.edg = out_edge;
      hv.sat = out_sat;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_fail++; $display("[TB] FAIL rnd_extra: got beat mag=%h want none", out_mag);
        end else begin
          e = exp_q.pop_front();
          n_vec++;
          if (out_mag !== e.mag || out_edge !== e.edg || out_sat !== e.sat) begin
            n_fail++; $display("[TB] FAIL rnd_data: got %h/%b/%b want %h/%b/%b", out_mag, out_edge, out_sat, e.mag, e.edg, e.sat);
          end
          inflight--;
        end
        recv++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_gx, in_gy, thresh));
        sent++;
        inflight++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    n_vec++; if (recv != sent || exp_q.size() != 0) begin n_fail++; $display("[TB] FAIL rnd_drain: got %0d beats (%0d pending) want %0d (0)", recv, exp_q.size(), sent); end
  endtask

  task automatic test_reset_mid();
    bit leaked = 1'b0;
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_gx     = pack4(9, 9, 9, 9);
    in_gy     = pack4(1, 1, 1, 1);
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0;
    n_vec++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_full_ready: got %b want 0", in_ready); end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_out_valid: got %b want 0", out_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_in_ready: got %b want 1", in_ready); end
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1 if (out_valid !== 1'b0) leaked = 1'b1;
    end
    n_vec++; if (leaked) begin n_fail++; $display("[TB] FAIL mid_stale: got stale beat want none"); end
  endtask

`ifdef ABS_MAG_SATCNT_EN
  task automatic test_sat_count();
    int exp_cnt = 0;
    do_reset();
    n_vec++; if (sat_count !== 16'd0) begin n_fail++; $display("[TB] FAIL cnt_reset: got %0d want 0", sat_count); end
    send_one(pack4(-2048, -2048, -2048, -2048), pack4(-2048, -2048, -2048, -2048), 12'd0);
    exp_cnt += $countones(model(pack4(-2048, -2048, -2048, -2048), pack4(-2048, -2048, -2048, -2048), 12'd0).sat);
    send_one(pack4(-2048, -2048, 0, 0), pack4(-2048, -2048, 0, 0), 12'd0);
    exp_cnt += $countones(model(pack4(-2048, -2048, 0, 0), pack4(-2048, -2048, 0, 0), 12'd0).sat);
    send_one(pack4(1, 1, 1, 1), '0, 12'd0);
    exp_cnt += $countones(model(pack4(1, 1, 1, 1), '0, 12'd0).sat);
    @(posedge clk);
    #1;
    n_vec++; if (sat_count !== 16'd6 || exp_cnt != 6) begin n_fail++; $display("[TB] FAIL cnt_sum: got %0d want 6 (model %0d)", sat_count, exp_cnt); end
    in_gx     = pack4(-2048, -2048, -2048, -2048);
    in_gy     = pack4(-2048, -2048, -2048, -2048);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    repeat (16400) @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (sat_count !== 16'hFFFF) begin n_fail++; $display("[TB] FAIL cnt_saturate: got %h want ffff", sat_count); end
  endtask
`endif

  initial begin
    test_reset();
    do_reset();
    test_basic();
    test_most_negative();
    test_threshold();
    do_reset();
    test_back_pressure();
    do_reset();
    test_random_stream();
    test_reset_mid();
`ifdef ABS_MAG_SATCNT_EN
    test_sat_count();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
